// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_mem
// Description : Loadable instruction memory with a one-deep registered,
//               valid/ready fetch port, flush and fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================

module instr_fetch_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en,
  input  logic [$clog2(DEPTH)-1:0]     load_idx,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_pc,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_instr,
  output logic [ADDR_W-1:0]            rsp_pc,
  output logic                         rsp_fault,
  output logic [15:0]                  fault_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] c_depth_addr = ADDR_W'(DEPTH);
  localparam logic [IDX_W:0]    c_depth_idx  = (IDX_W + 1)'(DEPTH);
  localparam logic [15:0]       c_cnt_max    = 16'hFFFF;

  localparam logic [0:0] c_empty = 1'b0;
  localparam logic [0:0] c_full  = 1'b1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_accept;
  logic              w_fault;
  logic              w_load_ok;
  logic [ADDR_W-1:0] w_word_addr;
  logic [IDX_W-1:0]  w_rd_idx;

  // Range check uses the full-width word address so high PC bits cannot alias
  // onto a valid index.
  always_comb begin
    w_word_addr = req_pc >> 2;
    w_rd_idx    = w_word_addr[IDX_W-1:0];
    w_fault     = (req_pc[1:0] != 2'b00) || (w_word_addr >= c_depth_addr);
    w_load_ok   = load_en && ({1'b0, load_idx} < c_depth_idx);
    w_accept    = req_valid && req_ready;
  end

  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_empty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_empty;
    end else begin
      case (r_state)
        c_empty: begin
          if (w_accept) w_state_nxt = c_full;
        end
        c_full: begin
          if (rsp_ready) w_state_nxt = w_accept ? c_full : c_empty;
        end
        default: w_state_nxt = c_empty;
      endcase
    end
  end

  always_comb begin
    rsp_valid = (r_state == c_full);
    req_ready = !load_en && !flush && ((r_state == c_empty) || rsp_ready);
  end

  // Response payload only moves on acceptance, so a stalled response stays
  // stable even if its memory word is rewritten underneath it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_instr <= '0;
      rsp_pc    <= '0;
      rsp_fault <= 1'b0;
    end else if (flush) begin
      rsp_instr <= '0;
      rsp_pc    <= '0;
      rsp_fault <= 1'b0;
    end else if (w_accept) begin
      rsp_pc    <= req_pc;
      rsp_fault <= w_fault;
      rsp_instr <= w_fault ? '0 : r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_cnt <= '0;
    end else if (rsp_valid && rsp_ready && rsp_fault && (fault_cnt != c_cnt_max)) begin
      fault_cnt <= fault_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_mem
// Description : Directed vector bench for instr_fetch_mem (DEPTH=64).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_instr_fetch_mem;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_idx;
  logic [31:0] load_data;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic        rsp_fault;
  logic [15:0] fault_cnt;

  int errors = 0;
  int checks = 0;

  instr_fetch_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_data (load_data),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .fault_cnt (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        le;
    logic [5:0]  li;
    logic [31:0] ld;
    logic        fl;
    logic        rv;
    logic [31:0] pc;
    logic        rr;
    logic        e_rdy;
    logic        e_v;
    logic        cd;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_f;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic le, input logic [5:0] li, input logic [31:0] ld,
                              input logic fl, input logic rv, input logic [31:0] pc,
                              input logic rr, input logic e_rdy, input logic e_v,
                              input logic cd, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_f,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.le = le; v.li = li; v.ld = ld; v.fl = fl; v.rv = rv; v.pc = pc; v.rr = rr;
    v.e_rdy = e_rdy; v.e_v = e_v; v.cd = cd; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_f = e_f; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [31:0] prog [7];

  initial begin
    prog[0] = 32'hF8400281; prog[1] = 32'h8B010022; prog[2] = 32'hD1000333;
    prog[3] = 32'hB40000E3; prog[4] = 32'h91002294; prog[5] = 32'hF81F4281;
    prog[6] = 32'h17FFFFFA;

    // Program load with a fetch pending: never ready, outputs stay at reset.
    for (int k = 0; k < 7; k++)
      add(1, 6'(k), prog[k], 0, 1, 32'd0, 1, 0, 0, 1, 32'd0, 32'd0, 0, 16'd0);
    add(1, 6'd63, 32'h0BADF00D, 0, 1, 32'd0, 1, 0, 0, 1, 32'd0, 32'd0, 0, 16'd0);
    // Back-to-back stream, one response per cycle.
    for (int k = 0; k < 7; k++)
      add(0, 6'd0, 32'd0, 0, 1, 32'(4 * k), 1, 1, 1, 1, prog[k], 32'(4 * k), 0, 16'd0);
    // Backpressure on pc=8; a load to the held index mid-stall.
    add(0, 6'd0, 32'd0, 0, 1, 32'd8,  1, 1, 1, 1, 32'hD1000333, 32'd8, 0, 16'd0);
    add(0, 6'd0, 32'd0, 0, 1, 32'd12, 0, 0, 1, 1, 32'hD1000333, 32'd8, 0, 16'd0);
    add(1, 6'd2, 32'hDEADBEEF, 0, 1, 32'd12, 0, 0, 1, 1, 32'hD1000333, 32'd8, 0, 16'd0);
    add(0, 6'd0, 32'd0, 0, 1, 32'd12, 0, 0, 1, 1, 32'hD1000333, 32'd8, 0, 16'd0);
    add(0, 6'd0, 32'd0, 0, 1, 32'd12, 1, 1, 1, 1, 32'hB40000E3, 32'd12, 0, 16'd0);
    // Last valid word, then misaligned and out-of-range faults.
    add(0, 6'd0, 32'd0, 0, 1, 32'd252, 1, 1, 1, 1, 32'h0BADF00D, 32'd252, 0, 16'd0);
    add(0, 6'd0, 32'd0, 0, 1, 32'd6,   1, 1, 1, 1, 32'd0, 32'd6, 1, 16'd0);
    add(0, 6'd0, 32'd0, 0, 1, 32'd256, 1, 1, 1, 1, 32'd0, 32'd256, 1, 16'd1);
    add(0, 6'd0, 32'd0, 0, 0, 32'd0,   1, 1, 0, 0, 32'd0, 32'd0, 0, 16'd2);
    // High PC bits must not alias onto index 0.
    add(0, 6'd0, 32'd0, 0, 1, 32'h4000_0000, 1, 1, 1, 1, 32'd0, 32'h4000_0000, 1, 16'd2);
    add(0, 6'd0, 32'd0, 0, 0, 32'd0, 1, 1, 0, 0, 32'd0, 32'd0, 0, 16'd3);
    // Flush while full with a request offered.
    add(0, 6'd0, 32'd0, 0, 1, 32'd16, 1, 1, 1, 1, 32'h91002294, 32'd16, 0, 16'd3);
    add(0, 6'd0, 32'd0, 1, 1, 32'd20, 0, 0, 0, 1, 32'd0, 32'd0, 0, 16'd3);
    add(0, 6'd0, 32'd0, 0, 0, 32'd0,  1, 1, 0, 1, 32'd0, 32'd0, 0, 16'd3);
    // Two load cycles with a fetch pending, then read back the new words.
    add(1, 6'd5, 32'h12345678, 0, 1, 32'd20, 1, 0, 0, 0, 32'd0, 32'd0, 0, 16'd3);
    add(1, 6'd4, 32'hCAFEF00D, 0, 1, 32'd20, 1, 0, 0, 0, 32'd0, 32'd0, 0, 16'd3);
    add(0, 6'd0, 32'd0, 0, 1, 32'd20, 1, 1, 1, 1, 32'h12345678, 32'd20, 0, 16'd3);
    add(0, 6'd0, 32'd0, 0, 1, 32'd16, 1, 1, 1, 1, 32'hCAFEF00D, 32'd16, 0, 16'd3);
    add(0, 6'd0, 32'd0, 0, 0, 32'd0,  1, 1, 0, 0, 32'd0, 32'd0, 0, 16'd3);

    reset = 1'b1; load_en = 0; load_idx = '0; load_data = '0; flush = 0;
    req_valid = 0; req_pc = '0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_instr", rsp_instr, 32'd0);
    chk("reset_pc",    rsp_pc,    32'd0);
    chk("reset_fault", 32'(rsp_fault), 32'd0);
    chk("reset_cnt",   32'(fault_cnt), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      load_en = vecs[i].le; load_idx = vecs[i].li; load_data = vecs[i].ld;
      flush = vecs[i].fl; req_valid = vecs[i].rv; req_pc = vecs[i].pc;
      rsp_ready = vecs[i].rr;
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_fault_cnt", i), 32'(fault_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].cd) begin
        chk($sformatf("v%0d_rsp_instr", i), rsp_instr, vecs[i].e_instr);
        chk($sformatf("v%0d_rsp_pc", i),    rsp_pc,    vecs[i].e_pc);
        chk($sformatf("v%0d_rsp_fault", i), 32'(rsp_fault), 32'(vecs[i].e_f));
      end
    end

    // Async reset while full and stalled; memory must survive it.
    load_en = 0; flush = 0; req_valid = 1; req_pc = 32'd8; rsp_ready = 0;
    @(posedge clk);
    #1;
    chk("r5_full_valid", 32'(rsp_valid), 32'd1);
    chk("r5_full_instr", rsp_instr, 32'hDEADBEEF);
    req_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("r5_async_valid", 32'(rsp_valid), 32'd0);
    chk("r5_async_instr", rsp_instr, 32'd0);
    chk("r5_async_pc",    rsp_pc,    32'd0);
    chk("r5_async_cnt",   32'(fault_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 1; req_pc = 32'd4; rsp_ready = 1;
    @(posedge clk);
    #1;
    chk("r5_refetch_valid", 32'(rsp_valid), 32'd1);
    chk("r5_refetch_instr", rsp_instr, 32'h8B010022);
    chk("r5_refetch_pc",    rsp_pc,    32'd4);
    req_valid = 0;
    @(posedge clk);
    #1;
    chk("r5_drain_valid", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
